// File: rtl/csr_trap_ctrl.sv
// Trap/return sequencer: on an exception, interrupt or mret it holds the
// pipeline, walks the machine CSRs through the shared write port one per
// cycle, and then issues a single-cycle redirect.
module csr_trap_ctrl #(
    parameter logic [31:0] INT_CAUSE = 32'h8000_0007
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_req_i,
    input  logic [31:0] exc_cause_i,
    input  logic [31:0] exc_pc_i,
    input  logic        int_req_i,
    input  logic [31:0] int_pc_i,
    input  logic        mret_i,
    input  logic        ex_csr_we_i,
    input  logic        global_int_en_i,
    input  logic [31:0] csr_mtvec_i,
    input  logic [31:0] csr_mepc_i,
    input  logic [31:0] csr_mstatus_i,
    output logic        csr_we_o,
    output logic [31:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic        hold_o,
    output logic        jump_o,
    output logic [31:0] jump_addr_o
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] ADDR_MSTATUS = XLEN'(32'h300);
    localparam logic [XLEN-1:0] ADDR_MEPC    = XLEN'(32'h341);
    localparam logic [XLEN-1:0] ADDR_MCAUSE  = XLEN'(32'h342);
    localparam logic [XLEN-1:0] MIE_MPIE     = XLEN'(32'h88);
    localparam logic [XLEN-1:0] MIE_BIT      = XLEN'(32'h08);
    localparam logic [XLEN-1:0] MPIE_BIT     = XLEN'(32'h80);
    localparam logic [XLEN-1:0] ALIGN_MASK   = ~XLEN'(32'h3);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T_MEPC,
        S_T_MSTATUS,
        S_T_MCAUSE,
        S_T_JUMP,
        S_R_MSTATUS,
        S_R_JUMP
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] mstatus_q, mstatus_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] waddr_q, waddr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            jump_q, jump_d;
    logic [XLEN-1:0] jaddr_q, jaddr_d;
    logic            take_exc_c, take_mret_c, take_int_c, accept_c;

    // Request arbitration: ex-stage CSR writes block everything, then exc > mret > int.
    assign take_exc_c  = !ex_csr_we_i && exc_req_i;
    assign take_mret_c = !ex_csr_we_i && !exc_req_i && mret_i;
    assign take_int_c  = !ex_csr_we_i && !exc_req_i && !mret_i && int_req_i && global_int_en_i;

    // Next state, operand capture and next registered outputs.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cause_d   = cause_q;
        mstatus_d = mstatus_q;
        tgt_d     = tgt_q;
        accept_c  = 1'b0;
        we_d      = 1'b0;
        waddr_d   = '0;
        wdata_d   = '0;
        jump_d    = 1'b0;
        jaddr_d   = '0;

        case (state_q)
            S_IDLE: begin
                if (take_exc_c || take_int_c) begin
                    accept_c  = 1'b1;
                    pc_d      = take_exc_c ? exc_pc_i : int_pc_i;
                    cause_d   = take_exc_c ? exc_cause_i : INT_CAUSE;
                    mstatus_d = csr_mstatus_i;
                    tgt_d     = csr_mtvec_i & ALIGN_MASK;
                    state_d   = S_T_MEPC;
                end else if (take_mret_c) begin
                    accept_c  = 1'b1;
                    mstatus_d = csr_mstatus_i;
                    tgt_d     = csr_mepc_i;
                    state_d   = S_R_MSTATUS;
                end
            end
            S_T_MEPC:    state_d = S_T_MSTATUS;
            S_T_MSTATUS: state_d = S_T_MCAUSE;
            S_T_MCAUSE:  state_d = S_T_JUMP;
            S_T_JUMP:    state_d = S_IDLE;
            S_R_MSTATUS: state_d = S_R_JUMP;
            S_R_JUMP:    state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase

        case (state_d)
            S_T_MEPC: begin
                we_d    = 1'b1;
                waddr_d = ADDR_MEPC;
                wdata_d = pc_d;
            end
            S_T_MSTATUS: begin
                we_d    = 1'b1;
                waddr_d = ADDR_MSTATUS;
                wdata_d = (mstatus_d & ~MIE_MPIE) | (mstatus_d[3] ? MPIE_BIT : '0);
            end
            S_T_MCAUSE: begin
                we_d    = 1'b1;
                waddr_d = ADDR_MCAUSE;
                wdata_d = cause_d;
            end
            S_R_MSTATUS: begin
                we_d    = 1'b1;
                waddr_d = ADDR_MSTATUS;
                wdata_d = (mstatus_d & ~MIE_BIT) | (mstatus_d[7] ? MIE_BIT : '0) | MPIE_BIT;
            end
            S_T_JUMP, S_R_JUMP: begin
                jump_d  = 1'b1;
                jaddr_d = tgt_d;
            end
            default: ;
        endcase
    end

    // State, captured operands and output registers; reset aborts any sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            cause_q   <= '0;
            mstatus_q <= '0;
            tgt_q     <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            jump_q    <= 1'b0;
            jaddr_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cause_q   <= cause_d;
            mstatus_q <= mstatus_d;
            tgt_q     <= tgt_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            jump_q    <= jump_d;
            jaddr_q   <= jaddr_d;
        end
    end

    // Stall must rise in the acceptance cycle itself, so it is decoded directly.
    assign hold_o      = !rst && ((state_q != S_IDLE) || accept_c);
    assign csr_we_o    = we_q;
    assign csr_waddr_o = waddr_q;
    assign csr_wdata_o = wdata_q;
    assign jump_o      = jump_q;
    assign jump_addr_o = jaddr_q;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Scoreboard bench for csr_trap_ctrl: directed scenarios followed by random traffic.
module tb_csr_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_req_i, int_req_i, mret_i, ex_csr_we_i, global_int_en_i;
    logic [31:0] exc_cause_i, exc_pc_i, int_pc_i;
    logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
    logic        csr_we_o, hold_o, jump_o;
    logic [31:0] csr_waddr_o, csr_wdata_o, jump_addr_o;

    csr_trap_ctrl dut (
        .clk(clk), .rst(rst),
        .exc_req_i(exc_req_i), .exc_cause_i(exc_cause_i), .exc_pc_i(exc_pc_i),
        .int_req_i(int_req_i), .int_pc_i(int_pc_i), .mret_i(mret_i),
        .ex_csr_we_i(ex_csr_we_i), .global_int_en_i(global_int_en_i),
        .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i),
        .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
        .hold_o(hold_o), .jump_o(jump_o), .jump_addr_o(jump_addr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          is_jump;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    typedef struct {
        int cyc;
        bit val;
    } hold_t;

    ev_t   evq[$];
    hold_t hq[$];
    int    cyc = 0;
    int    busy = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    bit    mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock of stimulus; the reference model decides acceptance and queues expectations.
    task automatic step(input bit r, input bit xwe, input bit exc, input bit mr, input bit irq,
                        input bit ie, input logic [31:0] epc, input logic [31:0] ecause,
                        input logic [31:0] ipc, input logic [31:0] mtvec,
                        input logic [31:0] mepc, input logic [31:0] ms);
        bit in_seq;
        bit acc;
        @(posedge clk);
        #1;
        rst = r; ex_csr_we_i = xwe; exc_req_i = exc; mret_i = mr; int_req_i = irq;
        global_int_en_i = ie; exc_pc_i = epc; exc_cause_i = ecause; int_pc_i = ipc;
        csr_mtvec_i = mtvec; csr_mepc_i = mepc; csr_mstatus_i = ms;
        in_seq = (busy > 0);
        if (in_seq) busy--;
        acc = 1'b0;
        if (r) begin
            busy = 0;
            while (evq.size() > 0 && evq[evq.size()-1].cyc > cyc) void'(evq.pop_back());
        end else if (!in_seq && !xwe) begin
            if (exc || (!mr && irq && ie)) begin
                logic [31:0] newms;
                acc = 1'b1;
                busy = 4;
                newms = ms & ~32'h88;
                if (ms[3]) newms = newms + 32'h80;
                evq.push_back('{cyc + 1, 1'b0, 32'h341, exc ? epc : ipc});
                evq.push_back('{cyc + 2, 1'b0, 32'h300, newms});
                evq.push_back('{cyc + 3, 1'b0, 32'h342, exc ? ecause : 32'h8000_0007});
                evq.push_back('{cyc + 4, 1'b1, (mtvec >> 2) * 4, 32'h0});
            end else if (mr) begin
                logic [31:0] newms;
                acc = 1'b1;
                busy = 2;
                newms = (ms & ~32'h8) | 32'h80;
                if (ms[7]) newms = newms | 32'h8;
                evq.push_back('{cyc + 1, 1'b0, 32'h300, newms});
                evq.push_back('{cyc + 2, 1'b1, mepc, 32'h0});
            end
        end
        hq.push_back('{cyc, !r && (in_seq || acc)});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    always @(negedge clk) begin
        if (mon_en) begin
            while (evq.size() > 0 && evq[0].cyc < cyc) begin
                chk("missing_event_cycle", 32'(evq[0].cyc), 32'(cyc));
                void'(evq.pop_front());
            end
            if (csr_we_o || jump_o) begin
                if (evq.size() == 0 || evq[0].cyc != cyc) begin
                    chk("unexpected_output", {30'b0, csr_we_o, jump_o}, 32'h0);
                end else begin
                    ev_t e;
                    e = evq.pop_front();
                    chk("kind_we_jump", {30'b0, csr_we_o, jump_o}, e.is_jump ? 32'h1 : 32'h2);
                    if (e.is_jump) chk("jump_addr", jump_addr_o, e.addr);
                    else begin
                        chk("csr_waddr", csr_waddr_o, e.addr);
                        chk("csr_wdata", csr_wdata_o, e.data);
                    end
                end
            end
            if (!csr_we_o) begin
                chk("idle_waddr", csr_waddr_o, 32'h0);
                chk("idle_wdata", csr_wdata_o, 32'h0);
            end
            if (!jump_o) chk("idle_jump_addr", jump_addr_o, 32'h0);
            while (hq.size() > 0 && hq[0].cyc < cyc) begin
                chk("missing_hold_sample", 32'(hq[0].cyc), 32'(cyc));
                void'(hq.pop_front());
            end
            if (hq.size() > 0 && hq[0].cyc == cyc) begin
                hold_t h;
                h = hq.pop_front();
                chk("hold", {31'b0, hold_o}, {31'b0, h.val});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ex_csr_we_i = 0; exc_req_i = 0; mret_i = 0; int_req_i = 0;
        global_int_en_i = 0; exc_pc_i = 0; exc_cause_i = 0; int_pc_i = 0;
        csr_mtvec_i = 0; csr_mepc_i = 0; csr_mstatus_i = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", {31'b0, csr_we_o}, 32'h0);
        chk("rst_waddr", csr_waddr_o, 32'h0);
        chk("rst_wdata", csr_wdata_o, 32'h0);
        chk("rst_jump", {31'b0, jump_o}, 32'h0);
        chk("rst_jump_addr", jump_addr_o, 32'h0);
        chk("rst_hold", {31'b0, hold_o}, 32'h0);
        mon_en = 1'b1;
        idle(2);

        // ecall
        step(0, 0, 1, 0, 0, 0, 32'h100, 32'd11, 0, 32'h200, 0, 32'h8);
        idle(5);
        // masked interrupt, then enabled
        repeat (3) step(0, 0, 0, 0, 1, 0, 0, 0, 32'h44, 32'h300, 0, 32'h8);
        step(0, 0, 0, 0, 1, 1, 0, 0, 32'h44, 32'h300, 0, 32'h8);
        idle(5);
        // mret
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h104, 32'h80);
        idle(3);
        // all requests blocked by ex-stage CSR write, then exception wins
        repeat (2) step(0, 1, 1, 1, 1, 1, 32'h300, 32'd2, 32'h50, 32'h400, 32'h600, 32'h8);
        step(0, 0, 1, 1, 1, 1, 32'h300, 32'd2, 32'h50, 32'h400, 32'h600, 32'h8);
        idle(5);
        // reset while writing mstatus
        step(0, 0, 1, 0, 0, 0, 32'h120, 32'd3, 0, 32'h500, 0, 32'h0);
        idle(1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(5);
        // misaligned mtvec
        step(0, 0, 1, 0, 0, 0, 32'h140, 32'd11, 0, 32'h203, 0, 32'h88);
        idle(5);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(63) == 0, $urandom_range(3) == 0, $urandom_range(7) == 0,
                 $urandom_range(7) == 0, $urandom_range(3) == 0, $urandom_range(1) == 1,
                 $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
        end
        idle(8);
        chk("drain_events", 32'(evq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
